// File: rtl/spram_arbiter_pkg.sv
// Shared definitions for the single-port RAM arbiter: state encodings and the
// default RAM geometry shared with the 64x8 RAM.
package spram_arbiter_pkg;

   localparam int unsigned SpramWidth = 8;
   localparam int unsigned SpramAddr  = 6;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StTurn   = 2'd2
   } state_e;

endpackage

// File: rtl/spram_arbiter_if.sv
// Requester-side bus of the SPRAM arbiter: packed per-requester requests plus the
// grant pulse and tagged read-data return.
interface spram_arbiter_if #(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ADDR  = 6,
   parameter int unsigned IDW   = 3
);

   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       req_wr;
   logic [NREQ*ADDR-1:0]  req_addr;
   logic [NREQ*WIDTH-1:0] req_wdata;
   logic [NREQ-1:0]       gnt;
   logic                  rvalid;
   logic [IDW-1:0]        rid;
   logic [WIDTH-1:0]      rdata;

   modport master (
      output req, req_wr, req_addr, req_wdata,
      input  gnt, rvalid, rid, rdata
   );

   modport slave (
      input  req, req_wr, req_addr, req_wdata,
      output gnt, rvalid, rid, rdata
   );

endinterface

// File: rtl/spram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping
// to the lowest set bit below ptr.
module spram_arbiter_rr_pick #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IDW  = 3
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] onehot_o,
   output logic [IDW-1:0]  idx_o,
   output logic            valid_o
);

   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      valid_o  = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (!valid_o && req_i[j] && (IDW'(j) >= ptr_i)) begin
            valid_o     = 1'b1;
            onehot_o[j] = 1'b1;
            idx_o       = IDW'(j);
         end
      end
      // Nothing at or above ptr: the lowest set bit is the wrapped winner.
      for (int j = 0; j < NREQ; j++) begin
         if (!valid_o && req_i[j]) begin
            valid_o     = 1'b1;
            onehot_o[j] = 1'b1;
            idx_o       = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/spram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NREQ requesters.
// Define SPRAM_ARB_TURNAROUND_EN to add a dead bus cycle after every read access.
module spram_arbiter
   import spram_arbiter_pkg::*;
#(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned WIDTH = SpramWidth,
   parameter int unsigned ADDR  = SpramAddr,
   parameter int unsigned IDW   = 3
) (
   input  logic             clk,
   input  logic             rstn,
   spram_arbiter_if.slave   bus_if,
   output logic             mem_cs_o,
   output logic             mem_wr_o,
   output logic [ADDR-1:0]  mem_addr_o,
   inout  wire  [WIDTH-1:0] mem_data_io
);

   state_e            state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [IDW-1:0]    cur_q, cur_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              rvalid_q, rvalid_d;
   logic [IDW-1:0]    rid_q, rid_d;
   logic [WIDTH-1:0]  rdata_q, rdata_d;
   logic              cs_q, cs_d;
   logic              wr_q, wr_d;
   logic [ADDR-1:0]   addr_q, addr_d;
   logic [WIDTH-1:0]  wdata_q, wdata_d;
   logic              drv_q, drv_d;

   logic [NREQ-1:0]   pick_onehot;
   logic [IDW-1:0]    pick_idx;
   logic              pick_valid;
   logic              sel_wr;
   logic [ADDR-1:0]   sel_addr;
   logic [WIDTH-1:0]  sel_wdata;

   spram_arbiter_rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_pick (
      .req_i    (bus_if.req),
      .ptr_i    (ptr_q),
      .onehot_o (pick_onehot),
      .idx_o    (pick_idx),
      .valid_o  (pick_valid)
   );

   always_comb begin
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_onehot[i]) begin
            sel_wr    = bus_if.req_wr[i];
            sel_addr  = bus_if.req_addr[i*ADDR +: ADDR];
            sel_wdata = bus_if.req_wdata[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cur_d    = cur_q;
      gnt_d    = '0;
      rvalid_d = 1'b0;
      rid_d    = rid_q;
      rdata_d  = rdata_q;
      cs_d     = 1'b0;
      wr_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      drv_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               state_d = StAccess;
               cur_d   = pick_idx;
               gnt_d   = pick_onehot;
               cs_d    = 1'b1;
               wr_d    = sel_wr;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               drv_d   = sel_wr;
            end
         end
         StAccess: begin
            ptr_d   = (cur_q == IDW'(NREQ - 1)) ? '0 : cur_q + 1'b1;
            state_d = StIdle;
            if (!wr_q) begin
               rvalid_d = 1'b1;
               rid_d    = cur_q;
               rdata_d  = mem_data_io;
`ifdef SPRAM_ARB_TURNAROUND_EN
               state_d  = StTurn;
`endif
            end
         end
`ifdef SPRAM_ARB_TURNAROUND_EN
         StTurn: state_d = StIdle;
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         cur_q    <= '0;
         gnt_q    <= '0;
         rvalid_q <= 1'b0;
         rid_q    <= '0;
         rdata_q  <= '0;
         cs_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         drv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cur_q    <= cur_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         rid_q    <= rid_d;
         rdata_q  <= rdata_d;
         cs_q     <= cs_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         drv_q    <= drv_d;
      end
   end

   // Driver enable is its own register so it is only ever high during a write access.
   assign mem_data_io   = drv_q ? wdata_q : {WIDTH{1'bz}};
   assign mem_cs_o      = cs_q;
   assign mem_wr_o      = wr_q;
   assign mem_addr_o    = addr_q;
   assign bus_if.gnt    = gnt_q;
   assign bus_if.rvalid = rvalid_q;
   assign bus_if.rid    = rid_q;
   assign bus_if.rdata  = rdata_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed self-checking bench for spram_arbiter with NREQ=4 and a behavioural 64x8 RAM.
module tb_spram_arbiter;

   logic       clk = 1'b0;
   logic       rstn;
   logic       mem_cs;
   logic       mem_wr;
   logic [5:0] mem_addr;
   wire  [7:0] mem_data;
   logic [7:0] ram [64];
   int         errors = 0;
   int         checks = 0;

   spram_arbiter_if #(.NREQ(4), .WIDTH(8), .ADDR(6), .IDW(3)) bus ();

   spram_arbiter #(.NREQ(4), .WIDTH(8), .ADDR(6), .IDW(3)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .bus_if      (bus),
      .mem_cs_o    (mem_cs),
      .mem_wr_o    (mem_wr),
      .mem_addr_o  (mem_addr),
      .mem_data_io (mem_data)
   );

   always #5 clk = ~clk;

   // RAM drives reads; a 00 keeper drives the bus while deselected so any stray
   // arbiter drive shows up as a corrupted value.
   assign mem_data = !mem_cs ? 8'h00 : (mem_wr ? 8'hzz : ram[mem_addr]);

   always @(posedge clk) begin
      if (mem_cs && mem_wr) ram[mem_addr] <= mem_data;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      bus.req       = '0;
      bus.req_wr    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
   endtask

   task automatic set_req(input int idx, input logic wr, input logic [5:0] a,
                          input logic [7:0] d);
      bus.req[idx]             = 1'b1;
      bus.req_wr[idx]          = wr;
      bus.req_addr[idx*6 +: 6] = a;
      bus.req_wdata[idx*8 +: 8] = d;
   endtask

   task automatic do_reset();
      clear_req();
      rstn = 1'b0;
      step();
      step();
      rstn = 1'b1;
   endtask

   task automatic issue_write(input int idx, input logic [5:0] a, input logic [7:0] d);
      set_req(idx, 1'b1, a, d);
      step();
      clear_req();
      step();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.gnt !== 4'b0) begin errors++;
         $display("FAIL rst_gnt: got %b want 0000", bus.gnt); end
      checks++; if (bus.rvalid !== 1'b0 || bus.rid !== 3'd0 || bus.rdata !== 8'h00) begin
         errors++; $display("FAIL rst_rd: got rvalid=%b rid=%0d rdata=%h want 0 0 00",
                            bus.rvalid, bus.rid, bus.rdata); end
      checks++; if (mem_cs !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 6'h00) begin
         errors++; $display("FAIL rst_mem: got cs=%b wr=%b addr=%h want 0 0 00",
                            mem_cs, mem_wr, mem_addr); end
      checks++; if (mem_data !== 8'h00) begin errors++;
         $display("FAIL rst_bus: got %h want 00 (arbiter released)", mem_data); end
   endtask

   task automatic test_write_read();
      set_req(0, 1'b1, 6'h05, 8'hA5);
      step();
      checks++; if (bus.gnt !== 4'b0001 || mem_cs !== 1'b1 || mem_wr !== 1'b1) begin
         errors++; $display("FAIL wr_gnt: got gnt=%b cs=%b wr=%b want 0001 1 1",
                            bus.gnt, mem_cs, mem_wr); end
      checks++; if (mem_addr !== 6'h05 || mem_data !== 8'hA5) begin errors++;
         $display("FAIL wr_bus: got addr=%h data=%h want 05 A5", mem_addr, mem_data); end
      clear_req();
      step();
      checks++; if (bus.gnt !== 4'b0 || mem_cs !== 1'b0 || bus.rvalid !== 1'b0) begin
         errors++; $display("FAIL wr_done: got gnt=%b cs=%b rvalid=%b want 0000 0 0",
                            bus.gnt, mem_cs, bus.rvalid); end
      checks++; if (ram[5] !== 8'hA5) begin errors++;
         $display("FAIL wr_ram: got %h want A5", ram[5]); end
      // Stale wdata 5A differs from the stored A5, so arbiter contention would be visible.
      set_req(0, 1'b0, 6'h05, 8'h5A);
      step();
      checks++; if (bus.gnt !== 4'b0001 || mem_cs !== 1'b1 || mem_wr !== 1'b0) begin
         errors++; $display("FAIL rd_gnt: got gnt=%b cs=%b wr=%b want 0001 1 0",
                            bus.gnt, mem_cs, mem_wr); end
      checks++; if (mem_data !== 8'hA5) begin errors++;
         $display("FAIL rd_bus: got %h want A5", mem_data); end
      clear_req();
      step();
      checks++; if (bus.rvalid !== 1'b1 || bus.rid !== 3'd0 || bus.rdata !== 8'hA5) begin
         errors++; $display("FAIL rd_data: got rvalid=%b rid=%0d rdata=%h want 1 0 A5",
                            bus.rvalid, bus.rid, bus.rdata); end
      step();
      checks++; if (bus.rvalid !== 1'b0) begin errors++;
         $display("FAIL rd_pulse: got rvalid=%b want 0", bus.rvalid); end
   endtask

   task automatic test_contention();
      logic [3:0] exp_gnt;
      logic [7:0] exp_data;
      do_reset();
      issue_write(0, 6'h01, 8'h11);
      issue_write(1, 6'h02, 8'h22);
      set_req(0, 1'b0, 6'h01, 8'h00);
      set_req(1, 1'b0, 6'h02, 8'h00);
      for (int k = 0; k < 4; k++) begin
         exp_gnt  = (k % 2 == 0) ? 4'b0001 : 4'b0010;
         exp_data = (k % 2 == 0) ? 8'h11 : 8'h22;
         step();
         checks++; if (bus.gnt !== exp_gnt) begin errors++;
            $display("FAIL cont_gnt%0d: got %b want %b", k, bus.gnt, exp_gnt); end
         step();
         checks++; if (bus.rvalid !== 1'b1 || bus.rid !== 3'(k % 2) || bus.rdata !== exp_data)
         begin errors++; $display("FAIL cont_rd%0d: got rvalid=%b rid=%0d rdata=%h want 1 %0d %h",
                                  k, bus.rvalid, bus.rid, bus.rdata, k % 2, exp_data); end
      end
      clear_req();
      step();
   endtask

   task automatic test_wrap();
      // Pointer is 2 here; req3 wins alone, then pointer must wrap to 0.
      issue_write(3, 6'h3F, 8'hC3);
      checks++; if (ram[63] !== 8'hC3) begin errors++;
         $display("FAIL wrap_wr: got %h want C3", ram[63]); end
      set_req(0, 1'b0, 6'h3F, 8'h00);
      set_req(3, 1'b0, 6'h3F, 8'h00);
      step();
      checks++; if (bus.gnt !== 4'b0001 || mem_addr !== 6'h3F) begin errors++;
         $display("FAIL wrap_gnt0: got gnt=%b addr=%h want 0001 3F", bus.gnt, mem_addr); end
      bus.req[0] = 1'b0;
      step();
      checks++; if (bus.rvalid !== 1'b1 || bus.rid !== 3'd0 || bus.rdata !== 8'hC3) begin
         errors++; $display("FAIL wrap_rd0: got rvalid=%b rid=%0d rdata=%h want 1 0 C3",
                            bus.rvalid, bus.rid, bus.rdata); end
      step();
      checks++; if (bus.gnt !== 4'b1000) begin errors++;
         $display("FAIL wrap_gnt3: got %b want 1000", bus.gnt); end
      clear_req();
      step();
      checks++; if (bus.rvalid !== 1'b1 || bus.rid !== 3'd3 || bus.rdata !== 8'hC3) begin
         errors++; $display("FAIL wrap_rd3: got rvalid=%b rid=%0d rdata=%h want 1 3 C3",
                            bus.rvalid, bus.rid, bus.rdata); end
   endtask

   task automatic test_reset_mid();
      // Move the pointer off zero first so the reset of the pointer is observable.
      set_req(1, 1'b0, 6'h01, 8'h00);
      step();
      clear_req();
      step();
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 6'h05, 8'h00);
      step();
      checks++; if (bus.gnt !== 4'b0100 || mem_cs !== 1'b1) begin errors++;
         $display("FAIL mid_pre: got gnt=%b cs=%b want 0100 1", bus.gnt, mem_cs); end
      rstn = 1'b0;
      #1;
      checks++; if (mem_cs !== 1'b0 || bus.gnt !== 4'b0 || bus.rvalid !== 1'b0) begin
         errors++; $display("FAIL mid_rst: got cs=%b gnt=%b rvalid=%b want 0 0000 0",
                            mem_cs, bus.gnt, bus.rvalid); end
      step();
      rstn = 1'b1;
      step();
      checks++; if (bus.gnt !== 4'b0001 || bus.rvalid !== 1'b0) begin errors++;
         $display("FAIL mid_after: got gnt=%b rvalid=%b want 0001 0", bus.gnt, bus.rvalid); end
      clear_req();
      step();
      checks++; if (bus.rvalid !== 1'b1 || bus.rid !== 3'd0) begin errors++;
         $display("FAIL mid_rd: got rvalid=%b rid=%0d want 1 0", bus.rvalid, bus.rid); end
   endtask

   task automatic test_turnaround();
      do_reset();
      set_req(0, 1'b0, 6'h05, 8'h00);
      set_req(1, 1'b1, 6'h10, 8'h77);
      step();
      checks++; if (bus.gnt !== 4'b0001 || mem_wr !== 1'b0) begin errors++;
         $display("FAIL ta_rd: got gnt=%b wr=%b want 0001 0", bus.gnt, mem_wr); end
      bus.req[0] = 1'b0;
      step();
      checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 8'hA5 || mem_cs !== 1'b0) begin
         errors++; $display("FAIL ta_gap1: got rvalid=%b rdata=%h cs=%b want 1 A5 0",
                            bus.rvalid, bus.rdata, mem_cs); end
`ifdef SPRAM_ARB_TURNAROUND_EN
      step();
      checks++; if (mem_cs !== 1'b0 || bus.gnt !== 4'b0) begin errors++;
         $display("FAIL ta_gap2: got cs=%b gnt=%b want 0 0000", mem_cs, bus.gnt); end
`endif
      step();
      checks++; if (bus.gnt !== 4'b0010 || mem_cs !== 1'b1 || mem_wr !== 1'b1) begin
         errors++; $display("FAIL ta_wr: got gnt=%b cs=%b wr=%b want 0010 1 1",
                            bus.gnt, mem_cs, mem_wr); end
      checks++; if (mem_data !== 8'h77) begin errors++;
         $display("FAIL ta_bus: got %h want 77", mem_data); end
      clear_req();
      step();
      step();
   endtask

   initial begin
      rstn = 1'b0;
      clear_req();
      test_reset();
      test_write_read();
      test_contention();
      test_wrap();
      test_reset_mid();
      test_turnaround();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Shares one single-port RAM (cs/wr/addr plus bidirectional data bus) between NREQ requesters using round-robin arbitration.
- Owns the RAM control pins and the tristate driver on the data bus.
- Returns read data with a tagged valid pulse.
- Sits between client blocks and the 64x8 single-port RAM; the RAM itself is unchanged.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WIDTH, 8, data width; must match the RAM.
- ADDR, 6, address width; must match the RAM.
- IDW, 3, requester-index width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  clock; all state on posedge.
- rstn  input  1  reset, asynchronous, active-low.
- req  input  NREQ  per-requester request, level.
- req_wr  input  NREQ  per-requester direction: 1 = write, 0 = read.
- req_addr  input  NREQ*ADDR  packed addresses; requester i occupies slice [i*ADDR +: ADDR].
- req_wdata  input  NREQ*WIDTH  packed write data; requester i occupies slice [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot, one-cycle accept pulse.
- rvalid  output  1  read-data-valid pulse.
- rid  output  IDW  index of the requester owning rdata.
- rdata  output  WIDTH  read data.
- mem_cs  output  1  RAM chip select.
- mem_wr  output  1  RAM write enable.
- mem_addr  output  ADDR  RAM address.
- mem_data  inout  WIDTH  RAM data bus; driven only during a write access, otherwise high-Z.

Behaviour:
- States: IDLE, ACCESS, and TURN (TURN exists only with the optional feature). All outputs are registered.
- Reset (async, rstn=0):
  - State = IDLE.
  - gnt=0, rvalid=0, rid=0, rdata=0.
  - mem_cs=0, mem_wr=0, mem_addr=0; data driver disabled (high-Z).
  - Round-robin pointer = 0.
  - An in-flight access is abandoned; no gnt or rvalid is issued for it after reset.
- IDLE:
  - If req has no bits set, stay in IDLE with mem_cs=0.
  - Otherwise pick the winner w: the first set req bit searching upward from index ptr, wrapping NREQ-1 -> 0.
  - Latch req_wr[w], req_addr slice w and req_wdata slice w.
  - Next cycle: state ACCESS, mem_cs=1, mem_wr=req_wr[w], mem_addr=latched address, gnt[w]=1.
- ACCESS (exactly 1 cycle):
  - Write: mem_data is driven with the latched wdata for the whole cycle; the RAM captures it at the closing edge.
  - Read: mem_data is released; the RAM drives it combinationally. rdata<=mem_data is captured at the closing edge.
  - On the closing edge: ptr <= (w+1) mod NREQ. A read also sets rvalid=1 and rid=w for the following cycle.
  - Next state is IDLE, or TURN (feature on, access was a read). mem_cs and gnt return to 0.
- Latency and throughput:
  - Request sampled in IDLE at cycle N.
  - gnt and RAM access at cycle N+1.
  - rdata/rvalid at cycle N+2.
  - Peak throughput is one access per 2 cycles.
- Handshake rules:
  - A requester holds req, req_wr, addr and wdata stable until it sees gnt.
  - It may drop req, or present a new request, in the cycle after gnt.
  - Dropping req before gnt is allowed; that request is simply not served.
  - The arbiter never grants a requester whose req is low in IDLE.
- Boundary conditions:
  - All requesters active: strict rotation; each is served within NREQ accesses.
  - Winner is the last index (w = NREQ-1): ptr wraps to 0.
  - Address 0 and address 2**ADDR-1 pass through untouched; no address check is performed.
  - rvalid never coincides with a second rvalid for a different rid; at most one read is in flight.
  - The bus is never driven by the arbiter while mem_cs=1 and mem_wr=0.

Optional Feature:
- Macro: SPRAM_ARB_TURNAROUND_EN.
- Defined: after every read ACCESS, insert one TURN cycle (mem_cs=0, bus high-Z, no grant) before returning to IDLE. This guarantees a dead bus cycle between RAM-driven and arbiter-driven phases. Read-to-next-grant spacing becomes 3 cycles; rvalid timing is unchanged.
- Undefined: no TURN state; ACCESS always returns to IDLE.

Decomposition:
- Shared package/include spram_arb_defs holds:
  - State encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_TURN=2'd2.
  - A default-width localparam set (WIDTH/ADDR) shared with the RAM.
- Sub-module rr_pick: purely combinational. Input req and ptr; output the one-hot winner and its index. It is instantiated once; the pointer register stays in the parent.

Test Plan:
- Write then read: req0 write addr 6'h05 data 8'hA5, then req0 read addr 6'h05 -> gnt[0] pulses on both; rvalid=1, rid=0, rdata=8'hA5 two cycles after the read is sampled.
- Contention: req0 and req1 held continuously issuing reads from addr 1 and addr 2 -> grant order 0,1,0,1 with no starvation; rid alternates in step with the grants.
- Wrap boundary: NREQ=4, only req3 then req0 pending -> ptr moves 3 -> 0; both are granted once; last address 6'h3F reads back what was written.
- Bus ownership: during write ACCESS, mem_data equals wdata; during read ACCESS and in IDLE, the arbiter's driver is high-Z (check for no X from contention).
- Reset mid-access: deassert rstn during ACCESS of a read -> mem_cs=0, gnt=0 and rvalid=0 immediately; no rvalid after release; the first request after reset is granted to req0 when all requests are active.
- Turnaround (macro defined): read followed by a pending write -> one cycle with mem_cs=0 between the read ACCESS and the write grant; undefined -> the write is granted on the second cycle after the read ACCESS.
